// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Brief    : Shared defaults, counter sizing helpers and debounce state type
//            for the button conditioner (optional: BUTTON_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam int DEBOUNCE_TICKS_DEF = 4;
    localparam int REPEAT_DELAY_DEF   = 32;
    localparam int REPEAT_PERIOD_DEF  = 8;

    // Debounce counter must hold 0..DEBOUNCE_TICKS
    function automatic int cnt_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

    function automatic int rep_width(input int delay  = REPEAT_DELAY_DEF,
                                     input int period = REPEAT_PERIOD_DEF);
        return $clog2(delay + period + 1);
    endfunction

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_ch
// Brief    : One button channel: 2-flop sync, tick-qualified debounce, press
//            pulse, and repeat counter when BUTTON_AUTOREPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_pulse_nxt
);

    localparam int             c_CNT_W    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]         r_sync;
    logic               w_s;
    db_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_level, w_level_nxt;
    logic               r_pulse, w_pulse_nxt;
    logic               w_press;

    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // IDLE implies a zero count; any matching sample restarts the streak
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_press     = 1'b0;
        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (w_s != r_level) begin
                        if (c_CNT_LAST == '0) begin
                            w_level_nxt = w_s;
                            w_press     = w_s;
                        end else begin
                            w_cnt_nxt   = c_CNT_W'(1);
                            w_state_nxt = COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (w_s == r_level) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_level_nxt = w_s;
                        w_press     = w_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int                 c_REP_W    = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [c_REP_W-1:0] c_REP_FIRE = c_REP_W'(REPEAT_DELAY);
    localparam logic [c_REP_W-1:0] c_REP_WRAP = c_REP_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [c_REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc;
    logic               w_rep_fire;

    // Counter runs 0..DELAY once, then cycles DELAY..DELAY+PERIOD-1
    always_comb begin
        w_rep_inc  = r_rep + 1'b1;
        w_rep_nxt  = r_rep;
        w_rep_fire = 1'b0;
        if (!r_level) begin
            w_rep_nxt = '0;
        end else if (tick) begin
            w_rep_nxt  = (w_rep_inc == c_REP_WRAP) ? c_REP_FIRE : w_rep_inc;
            w_rep_fire = w_level_nxt &&
                         ((w_rep_inc == c_REP_FIRE) || (w_rep_inc == c_REP_WRAP));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end

    assign w_pulse_nxt = w_press | w_rep_fire;
`else
    assign w_pulse_nxt = w_press;
`endif

    assign o_level     = r_level;
    assign o_pulse     = r_pulse;
    assign o_pulse_nxt = w_pulse_nxt & ~reset;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : NUM_BTN independent debounced channels with press pulses and a
//            registered any_pulse (optional: BUTTON_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] pulse,
    output logic               any_pulse
);

    logic [NUM_BTN-1:0] w_pulse_nxt;
    logic               r_any_pulse;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
`ifdef BUTTON_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .i_btn       (btn_raw[gi]),
            .o_level     (level[gi]),
            .o_pulse     (pulse[gi]),
            .o_pulse_nxt (w_pulse_nxt[gi])
        );
    end

    // Registered from the channels' next-pulse values so it aligns with pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_pulse <= 1'b0;
        end else begin
            r_any_pulse <= |w_pulse_nxt;
        end
    end

    assign any_pulse = r_any_pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed self-checking bench with a press-pulse scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] level, pulse;
    logic       any_pulse;
    logic [0:0] btn1 = 1'b0;
    logic [0:0] level1, pulse1;
    logic       any1;

    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    button_conditioner #(.NUM_BTN(4), .DEBOUNCE_TICKS(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_raw),
        .level(level), .pulse(pulse), .any_pulse(any_pulse)
    );

    button_conditioner #(.NUM_BTN(1), .DEBOUNCE_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn1),
        .level(level1), .pulse(pulse1), .any_pulse(any1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end
    endtask

    // Every cycle with a pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (pulse !== 4'b0 || any_pulse !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(pulse), 32'h0);
                chk("unexpected_any", 32'(any_pulse), 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_pulse", 32'(pulse), 32'(mon_exp));
                chk("sb_any", 32'(any_pulse), 32'(|mon_exp));
            end
        end
    end

    initial begin
        // Reset
        reset = 1'b1;
        step(1'b1);
        step(1'b1);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_any", 32'(any_pulse), 32'h0);
        chk("rst_level1", 32'(level1), 32'h0);
        reset = 1'b0;

        // Single clean press
        btn_raw = 4'b0001;
        exp_q.push_back(4'b0001);
        step(1'b0);
        step(1'b0);
        ticks(3);
        chk("press_level_early", 32'(level), 32'h0);
        step(1'b1);
        chk("press_level", 32'(level), 32'h1);
        chk("press_pulse", 32'(pulse), 32'h1);
        chk("press_any", 32'(any_pulse), 32'h1);
        step(1'b0);
        chk("press_pulse_off", 32'(pulse), 32'h0);
        chk("press_any_off", 32'(any_pulse), 32'h0);
        step(1'b0);
        step(1'b0);

        // Bounce on channel 1: 1,0,1 across three ticks, then 0
        btn_raw = 4'b0011; step(1'b0); step(1'b0); step(1'b1);
        btn_raw = 4'b0001; step(1'b0); step(1'b0); step(1'b0); step(1'b1);
        btn_raw = 4'b0011; step(1'b0); step(1'b0); step(1'b0); step(1'b1);
        btn_raw = 4'b0001; step(1'b0); step(1'b0); step(1'b0);
        ticks(4);
        chk("bounce_level", 32'(level), 32'h1);
        chk("bounce_pulse", 32'(pulse), 32'h0);

        // Simultaneous presses on channels 1 and 2
        btn_raw = 4'b0111;
        exp_q.push_back(4'b0110);
        step(1'b0);
        step(1'b0);
        ticks(3);
        chk("simul_level_early", 32'(level), 32'h1);
        step(1'b1);
        chk("simul_level", 32'(level), 32'h7);
        chk("simul_pulse", 32'(pulse), 32'h6);
        chk("simul_any", 32'(any_pulse), 32'h1);
        step(1'b0); step(1'b0); step(1'b0);

        // Release channel 2: level falls, no pulse
        btn_raw = 4'b0011;
        step(1'b0);
        step(1'b0);
        ticks(3);
        chk("release_level_early", 32'(level), 32'h7);
        step(1'b1);
        chk("release_level", 32'(level), 32'h3);
        chk("release_pulse", 32'(pulse), 32'h0);
        step(1'b0); step(1'b0); step(1'b0);

        btn_raw = 4'b0000;
        step(1'b0);
        step(1'b0);
        ticks(4);
        chk("all_released", 32'(level), 32'h0);

        // Reset mid-debounce discards the partial count
        btn_raw = 4'b0001;
        step(1'b0);
        step(1'b0);
        ticks(2);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("midrst_level", 32'(level), 32'h0);
        chk("midrst_pulse", 32'(pulse), 32'h0);
        step(1'b0);
        step(1'b0);
        ticks(3);
        chk("midrst_level_early", 32'(level), 32'h0);
        exp_q.push_back(4'b0001);
        step(1'b1);
        chk("midrst_level_acc", 32'(level), 32'h1);
        chk("midrst_pulse_acc", 32'(pulse), 32'h1);
        step(1'b0); step(1'b0); step(1'b0);

        btn_raw = 4'b0000;
        step(1'b0);
        step(1'b0);
        ticks(4);
        chk("midrst_release", 32'(level), 32'h0);

        // Continuous tick; DEBOUNCE_TICKS=1 instance accepts on first differing sample
        btn_raw = 4'b1000;
        btn1 = 1'b1;
        exp_q.push_back(4'b1000);
        step(1'b1);
        step(1'b1);
        chk("dt1_level_early", 32'(level1), 32'h0);
        step(1'b1);
        chk("dt1_level", 32'(level1), 32'h1);
        chk("dt1_pulse", 32'(pulse1), 32'h1);
        chk("dt1_any", 32'(any1), 32'h1);
        step(1'b1);
        chk("dt1_pulse_off", 32'(pulse1), 32'h0);
        chk("cont_level_early4", 32'(level), 32'h0);
        step(1'b1);
        chk("cont_level_early5", 32'(level), 32'h0);
        step(1'b1);
        chk("cont_level", 32'(level), 32'h8);
        chk("cont_pulse", 32'(pulse), 32'h8);
        step(1'b1);
        chk("cont_pulse_off", 32'(pulse), 32'h0);
        chk("cont_level_hold", 32'(level), 32'h8);
        chk("dt1_level_hold", 32'(level1), 32'h1);

        step(1'b0);
        step(1'b0);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
